// File: rtl/dma_ctrl_pkg.sv
// Shared definitions for the page-copy DMA controller.
// Holds the controller state encoding and the default register/port
// addresses, which the system address decoder also uses.
package dma_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_ALIGN = 3'd2,
        ST_READ  = 3'd3,
        ST_WRITE = 3'd4
    } dma_state_t;

    localparam logic [15:0] DEF_DMA_REG_ADDR  = 16'h4014;
    localparam logic [15:0] DEF_DST_PORT_ADDR = 16'h2004;

endpackage

// File: rtl/dma_ctrl.sv
// Page-copy DMA controller and bus arbiter for the 6502 core.
// Passes the core bus through in IDLE; a core write to DMA_REG_ADDR freezes
// the core and copies XFER_LEN bytes from page {page,00} to DST_PORT_ADDR.
// Optional macro: DMA_ALIGN_EN inserts an ALIGN cycle so the first READ
// always lands on an even (parity==0) cycle.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   cpu_address/wr_data/wr_enable  core bus request
//   cpu_ce                     core clock enable (0 = core frozen)
//   mem_rd_data                memory read data (valid cycle after address)
//   mem_address/wr_data/wr_enable  arbitrated memory bus
//   dma_busy                   transfer in progress
module dma_ctrl
    import dma_ctrl_pkg::*;
#(
    parameter logic [15:0] DMA_REG_ADDR  = DEF_DMA_REG_ADDR,
    parameter logic [15:0] DST_PORT_ADDR = DEF_DST_PORT_ADDR,
    parameter int unsigned XFER_LEN      = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_address,
    input  logic [7:0]  cpu_wr_data,
    input  logic        cpu_wr_enable,
    output logic        cpu_ce,
    input  logic [7:0]  mem_rd_data,
    output logic [15:0] mem_address,
    output logic [7:0]  mem_wr_data,
    output logic        mem_wr_enable,
    output logic        dma_busy
);

    localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

    dma_state_t state;
    logic [7:0] page;
    logic [7:0] idx;

`ifdef DMA_ALIGN_EN
    logic parity;

    // Free-running cycle parity used to align the first READ.
    always_ff @(posedge clk) begin
        if (reset) parity <= 1'b0;
        else       parity <= ~parity;
    end
`endif

    // Controller state, source page and byte index.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            page  <= 8'd0;
            idx   <= 8'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cpu_wr_enable && (cpu_address == DMA_REG_ADDR)) begin
                        page  <= cpu_wr_data;
                        idx   <= 8'd0;
                        state <= ST_START;
                    end
                end
                ST_START: begin
`ifdef DMA_ALIGN_EN
                    state <= parity ? ST_READ : ST_ALIGN;
`else
                    state <= ST_READ;
`endif
                end
                ST_ALIGN: state <= ST_READ;
                ST_READ:  state <= ST_WRITE;
                ST_WRITE: begin
                    if (idx == LAST_IDX) begin
                        state <= ST_IDLE;
                    end else begin
                        idx   <= idx + 8'd1;
                        state <= ST_READ;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Bus arbitration decode; idx never carries into page.
    always_comb begin
        cpu_ce        = 1'b0;
        dma_busy      = 1'b1;
        mem_address   = cpu_address;
        mem_wr_data   = cpu_wr_data;
        mem_wr_enable = 1'b0;
        case (state)
            ST_IDLE: begin
                cpu_ce        = 1'b1;
                dma_busy      = 1'b0;
                mem_wr_enable = cpu_wr_enable;
            end
            ST_READ: begin
                mem_address = {page, idx};
            end
            ST_WRITE: begin
                mem_address   = DST_PORT_ADDR;
                mem_wr_data   = mem_rd_data;
                mem_wr_enable = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dma_ctrl.sv
// Self-checking bench for dma_ctrl: pass-through vectors, randomized page
// copies against a memory/transfer model, alignment, page wrap, a one-byte
// transfer instance, and reset during a copy.
module tb_dma_ctrl;
    import dma_ctrl_pkg::*;

    localparam logic [15:0] REG = 16'h4014;
    localparam logic [15:0] DST = 16'h2004;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] cpu_address = 16'h0;
    logic [7:0]  cpu_wr_data = 8'h0;
    logic        cpu_wr_enable = 1'b0;
    logic        cpu_ce;
    logic [7:0]  mem_rd_data = 8'h0;
    logic [15:0] mem_address;
    logic [7:0]  mem_wr_data;
    logic        mem_wr_enable;
    logic        dma_busy;

    logic [15:0] c1_address = 16'h0;
    logic [7:0]  c1_wr_data = 8'h0;
    logic        c1_wr_enable = 1'b0;
    logic        c1_ce;
    logic [7:0]  c1_rd_data = 8'h0;
    logic [15:0] c1_mem_address;
    logic [7:0]  c1_mem_wr_data;
    logic        c1_mem_wr_enable;
    logic        c1_busy;

    logic [7:0] mem [65536];
    int cyc = 0;
    int pass_cnt = 0;
    int total_cnt = 0;

    dma_ctrl dut (
        .clk(clk), .reset(reset),
        .cpu_address(cpu_address), .cpu_wr_data(cpu_wr_data),
        .cpu_wr_enable(cpu_wr_enable), .cpu_ce(cpu_ce),
        .mem_rd_data(mem_rd_data), .mem_address(mem_address),
        .mem_wr_data(mem_wr_data), .mem_wr_enable(mem_wr_enable),
        .dma_busy(dma_busy)
    );

    dma_ctrl #(.XFER_LEN(1)) dut1 (
        .clk(clk), .reset(reset),
        .cpu_address(c1_address), .cpu_wr_data(c1_wr_data),
        .cpu_wr_enable(c1_wr_enable), .cpu_ce(c1_ce),
        .mem_rd_data(c1_rd_data), .mem_address(c1_mem_address),
        .mem_wr_data(c1_mem_wr_data), .mem_wr_enable(c1_mem_wr_enable),
        .dma_busy(c1_busy)
    );

    always #5 clk = ~clk;

    // Synchronous single-port memory; dut1 only reads from it.
    always @(posedge clk) begin
        mem_rd_data <= mem[mem_address];
        c1_rd_data  <= mem[c1_mem_address];
        if (mem_wr_enable) mem[mem_address] <= mem_wr_data;
    end

    // Cycles since reset release; its LSB is the spec's parity.
    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] pick_page();
        logic [7:0] p;
        p = 8'($urandom);
        while (p == 8'h20 || p == 8'h40 || p[7:4] == 4'h5) p = 8'($urandom);
        return p;
    endfunction

    task automatic fill_page(input logic [7:0] pg);
        for (int i = 0; i < 256; i++) mem[{pg, 8'(i)}] = 8'($urandom);
    endtask

    // Full 256-byte copy; want_par (0/1) selects START parity, -1 = any.
    task automatic run_copy(input string tag, input logic [7:0] pg, input int want_par);
        logic [7:0]  exp_data [256];
        logic [15:0] prev_addr, last_rd;
        int stall, nwr, wr_err, rd_err, bad0, other_wr, busy_err, start_par, exp_stall;
        int prev_cyc, first_rd_cyc;
        for (int i = 0; i < 256; i++) exp_data[i] = mem[{pg, 8'(i)}];
        cpu_wr_enable = 1'b0;
        if (want_par >= 0) begin
            for (int k = 0; k < 3; k++) begin
                next_cycle();
                if ((cyc % 2) == want_par) break;
            end
        end
        next_cycle();
        cpu_address = REG; cpu_wr_data = pg; cpu_wr_enable = 1'b1;
        #1;
        check({tag, "_trig_we"}, 32'(mem_wr_enable), 32'd1);
        check({tag, "_trig_ce"}, 32'(cpu_ce), 32'd1);
        start_par = (cyc + 1) % 2;
        stall = 0; nwr = 0; wr_err = 0; rd_err = 0; bad0 = 0; other_wr = 0; busy_err = 0;
        prev_addr = 16'h0; last_rd = 16'h0; prev_cyc = 0; first_rd_cyc = -1;
        for (int c = 0; c < 2000; c++) begin
            next_cycle();
            cpu_address = 16'h5000 | 16'($urandom_range(0, 4095));
            cpu_wr_data = 8'($urandom);
            cpu_wr_enable = 1'($urandom_range(0, 1));
            #1;
            if (cpu_ce) break;
            stall++;
            if (!dma_busy) busy_err++;
            if (mem_address == 16'h0000) bad0++;
            if (mem_wr_enable) begin
                if (mem_address == DST && nwr < 256) begin
                    if (mem_wr_data !== exp_data[nwr]) wr_err++;
                    if (prev_addr !== {pg, 8'(nwr)}) rd_err++;
                    if (nwr == 0) first_rd_cyc = prev_cyc;
                    last_rd = prev_addr;
                    nwr++;
                end else other_wr++;
            end
            prev_addr = mem_address;
            prev_cyc = cyc;
        end
        check({tag, "_end_busy"}, 32'(dma_busy), 32'd0);
        cpu_wr_enable = 1'b0;
        exp_stall = 513;
`ifdef DMA_ALIGN_EN
        if (start_par == 0) exp_stall = 514;
        check({tag, "_first_rd_even"}, 32'(first_rd_cyc % 2), 32'd0);
`endif
        check({tag, "_stall"}, 32'(stall), 32'(exp_stall));
        check({tag, "_nwrites"}, 32'(nwr), 32'd256);
        check({tag, "_wdata_err"}, 32'(wr_err), 32'd0);
        check({tag, "_raddr_err"}, 32'(rd_err), 32'd0);
        check({tag, "_last_rd"}, 32'(last_rd), 32'({pg, 8'hFF}));
        check({tag, "_addr0"}, 32'(bad0), 32'd0);
        check({tag, "_stray_wr"}, 32'(other_wr), 32'd0);
        check({tag, "_busy_err"}, 32'(busy_err), 32'd0);
    endtask

    typedef struct {
        logic [15:0] a;
        logic [7:0]  d;
        logic        we;
        logic        exp_ce;
        logic        exp_busy;
    } pt_vec_t;

    initial begin
        pt_vec_t vecs [6];
        int nwr, bad;
        int sp;
        logic [7:0] pg;

        vecs[0] = '{16'h1234, 8'h5A, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{16'h0000, 8'h00, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{16'hFFFF, 8'hFF, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{16'h4014, 8'h77, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{16'h4015, 8'h03, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{16'h2004, 8'hC3, 1'b1, 1'b1, 1'b0};

        for (int i = 0; i < 65536; i++) mem[i] = 8'h0;
        mem[16'h2000] = 8'hA7;

        // Reset
        repeat (3) next_cycle();
        reset = 1'b0;
        cpu_address = 16'h0100; cpu_wr_enable = 1'b1;
        #1;
        check("rst_ce", 32'(cpu_ce), 32'd1);
        check("rst_busy", 32'(dma_busy), 32'd0);
        check("rst_we", 32'(mem_wr_enable), 32'd1);
        cpu_wr_enable = 1'b0;
        #1;
        check("rst_we_low", 32'(mem_wr_enable), 32'd0);

        // One-byte transfer instance, page 20
        next_cycle();
        c1_address = REG; c1_wr_data = 8'h20; c1_wr_enable = 1'b1;
        #1;
        check("len1_trig_we", 32'(c1_mem_wr_enable), 32'd1);
        sp = (cyc + 1) % 2;
        next_cycle();
        c1_address = 16'h7777; c1_wr_enable = 1'b1;
        #1;
        check("len1_start_ce", 32'(c1_ce), 32'd0);
        check("len1_start_busy", 32'(c1_busy), 32'd1);
        check("len1_start_we", 32'(c1_mem_wr_enable), 32'd0);
        check("len1_start_addr", 32'(c1_mem_address), 32'h7777);
`ifdef DMA_ALIGN_EN
        if (sp == 0) next_cycle();
`endif
        next_cycle();
        check("len1_rd_addr", 32'(c1_mem_address), 32'h2000);
        check("len1_rd_we", 32'(c1_mem_wr_enable), 32'd0);
        next_cycle();
        check("len1_wr_addr", 32'(c1_mem_address), 32'(DST));
        check("len1_wr_we", 32'(c1_mem_wr_enable), 32'd1);
        check("len1_wr_data", 32'(c1_mem_wr_data), 32'hA7);
        c1_wr_enable = 1'b0;
        next_cycle();
        check("len1_idle_ce", 32'(c1_ce), 32'd1);
        check("len1_idle_busy", 32'(c1_busy), 32'd0);

        // Pass-through vectors
        for (int i = 0; i < 6; i++) begin
            next_cycle();
            cpu_address = vecs[i].a; cpu_wr_data = vecs[i].d; cpu_wr_enable = vecs[i].we;
            #1;
            check("pt_addr", 32'(mem_address), 32'(vecs[i].a));
            check("pt_data", 32'(mem_wr_data), 32'(vecs[i].d));
            check("pt_we", 32'(mem_wr_enable), 32'(vecs[i].we));
            check("pt_ce", 32'(cpu_ce), 32'(vecs[i].exp_ce));
            check("pt_busy", 32'(dma_busy), 32'(vecs[i].exp_busy));
        end
        for (int i = 0; i < 8; i++) begin
            logic [15:0] a;
            logic        we;
            next_cycle();
            a = 16'($urandom);
            we = 1'($urandom_range(0, 1));
            if (a == REG) we = 1'b0;
            cpu_address = a; cpu_wr_data = 8'($urandom); cpu_wr_enable = we;
            #1;
            check("ptr_addr", 32'(mem_address), 32'(a));
            check("ptr_data", 32'(mem_wr_data), 32'(cpu_wr_data));
            check("ptr_we", 32'(mem_wr_enable), 32'(we));
            check("ptr_ce", 32'(cpu_ce), 32'd1);
        end
        cpu_wr_enable = 1'b0;

        // Full copy of page 03 preloaded with its offset
        for (int i = 0; i < 256; i++) mem[16'h0300 + i] = 8'(i);
        run_copy("copy03", 8'h03, -1);

        // START parity 0 and 1
        pg = pick_page(); fill_page(pg);
        run_copy("align0", pg, 0);
        pg = pick_page(); fill_page(pg);
        run_copy("align1", pg, 1);

        // Page wrap at FF
        fill_page(8'hFF);
        run_copy("wrapFF", 8'hFF, -1);

        // Reset at byte 100
        fill_page(8'h12);
        next_cycle();
        cpu_address = REG; cpu_wr_data = 8'h12; cpu_wr_enable = 1'b1;
        nwr = 0;
        for (int c = 0; c < 400 && nwr < 100; c++) begin
            next_cycle();
            cpu_wr_enable = 1'b0;
            #1;
            if (mem_wr_enable && mem_address == DST) nwr++;
        end
        check("rmid_reached", 32'(nwr), 32'd100);
        next_cycle();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        cpu_address = 16'h1111; cpu_wr_data = 8'h33; cpu_wr_enable = 1'b1;
        #1;
        check("rmid_ce", 32'(cpu_ce), 32'd1);
        check("rmid_busy", 32'(dma_busy), 32'd0);
        check("rmid_we", 32'(mem_wr_enable), 32'd1);
        check("rmid_addr", 32'(mem_address), 32'h1111);
        cpu_wr_enable = 1'b0;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            next_cycle();
            if (!cpu_ce || (mem_wr_enable && mem_address == DST)) bad++;
        end
        check("rmid_quiet", 32'(bad), 32'd0);
        pg = pick_page(); fill_page(pg);
        run_copy("after_rst", pg, -1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/dma_ctrl.md
# dma_ctrl

Page-copy DMA controller and bus arbiter between the 6502 core and its single-port synchronous memory bus. In normal operation it passes the core's bus through unchanged. A CPU write to the DMA register starts a copy: the controller freezes the core via a clock enable and copies `XFER_LEN` bytes from page `{page,00}` to a fixed destination port. When the copy finishes, it returns the bus to the core.

## Interface
- `DMA_REG_ADDR`, default 16'h4014: CPU write address that starts a transfer; the written byte is the source page.
- `DST_PORT_ADDR`, default 16'h2004: destination address for every DMA write.
- `XFER_LEN`, default 256: bytes per transfer; legal range 1..256.
- `clk`  in  1: system clock.
- `reset`  in  1: synchronous, active-high reset.
- `cpu_address`  in  16: core address.
- `cpu_wr_data`  in  8: core write data.
- `cpu_wr_enable`  in  1: core write strobe.
- `cpu_ce`  out  1: core clock enable; low freezes all core state.
- `mem_rd_data`  in  8: memory read data. It is valid the cycle after its address is presented. It also feeds the core directly.
- `mem_address`  out  16: arbitrated address.
- `mem_wr_data`  out  8: arbitrated write data.
- `mem_wr_enable`  out  1: arbitrated write strobe.
- `dma_busy`  out  1: high from START through the last WRITE.

## Operation
- States: IDLE, START, ALIGN (only with macro), READ, WRITE. State, `page[7:0]`, `idx[7:0]` and `parity` are registered. All outputs are combinational decode of state and registers.
- IDLE:
  - `mem_*` = `cpu_*`; `cpu_ce`=1.
  - If `cpu_wr_enable` && `cpu_address`==`DMA_REG_ADDR`: latch `page`<=`cpu_wr_data`, `idx`<=0, go to START. The triggering write still reaches memory.
- START:
  - `cpu_ce`=0, `mem_wr_enable`=0, `mem_address`=`cpu_address`.
  - Go to ALIGN or READ (see Configuration).
- ALIGN: same outputs as START; go to READ.
- READ: `mem_address`={`page`,`idx`}, `mem_wr_enable`=0; go to WRITE.
- WRITE:
  - `mem_address`=`DST_PORT_ADDR`, `mem_wr_data`=`mem_rd_data` (direct pass-through; the byte read in the previous cycle), `mem_wr_enable`=1.
  - If `idx`==`XFER_LEN`-1: go to IDLE. Otherwise `idx`<=`idx`+1 and go to READ.
- `idx` never carries into `page`; with `page`=8'hFF the source range is FF00–FFFF.
- `parity` toggles every cycle and resets to 0.
- `cpu_ce`=0 in every non-IDLE state. Core bus inputs are ignored outside IDLE.
- Reset in any state: next cycle is IDLE, with `cpu_ce`=1, `dma_busy`=0, `mem_wr_enable`=`cpu_wr_enable`, `idx`=0, `page`=0, `parity`=0. A partial copy is abandoned and not resumed.

## Timing
- Cycle T: trigger write accepted in IDLE.
- T+1: START.
- First READ at T+2, or at T+3 when ALIGN is inserted.
- Each byte takes 2 cycles. The last WRITE is followed by IDLE, and `cpu_ce`=1 in that cycle.
- Core stall length = 1 + 2·`XFER_LEN` (+1 if ALIGN is inserted): 513 or 514 cycles at 256.
- No back-to-back trigger is possible; the core is frozen for the whole transfer.

## Configuration
- `DMA_ALIGN_EN` defined: START goes to ALIGN when `parity`==0 in START. The first READ therefore always falls on a `parity`==0 cycle.
- `DMA_ALIGN_EN` undefined: ALIGN state and `parity` are removed. START always goes to READ, and the stall is always 1 + 2·`XFER_LEN`.

## Structure
- Shared package holds:
  - `dma_state_t` enum (IDLE, START, ALIGN, READ, WRITE);
  - default `DMA_REG_ADDR`/`DST_PORT_ADDR` constants, shared with the address decoder.
- Single module; no sub-module is warranted.

## Test plan
- Pass-through: in IDLE, `cpu_address`=16'h1234, `cpu_wr_data`=8'h5A, `cpu_wr_enable`=1 -> same values on `mem_*`; `cpu_ce`=1, `dma_busy`=0.
- Full copy: preload 0300–03FF with i, write 8'h03 to 16'h4014 -> 256 writes to 16'h2004 with data 00..FF in order, and each READ address is 16'h0300+i. Stall is 513 cycles (macro off); `cpu_ce` returns to 1.
- Align: with `DMA_ALIGN_EN`, trigger so that START has `parity`=0 -> 514-cycle stall and first READ on an even cycle. Trigger so that START has `parity`=1 -> 513-cycle stall.
- Page wrap: write 8'hFF with `XFER_LEN`=256 -> last READ at 16'hFFFF and no access to 16'h0000.
- Short length: `XFER_LEN`=1, page 8'h20 -> one READ at 16'h2000 and one WRITE, then IDLE at T+4 (macro off).
- Reset mid-transfer: assert `reset` at byte 100 -> next cycle IDLE, `cpu_ce`=1, no further writes to 16'h2004. A new trigger then starts at `idx`=0.
